regfile_wr_arbiter: RTL and testbench

Shares the register file's single write port among NREQ writeback requesters (ALU, load unit, debug port) with round-robin arbitration and a registered write stage. It sits between the execute/writeback sources and the 16 x 16-bit register file. It drives the file's write_en/write_address/write_data and exports the in-flight write so decode can detect read-after-write hazards.

---
 rtl/regfile_wr_arbiter.sv | 89 ++++++++
 tb/tb_regfile_wr_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file's single write port, with a registered write stage.
// Optional macro REGFILE_WR_R0_ZERO_EN: writes to address 0 are accepted but suppressed (r0 reads as zero).
module regfile_wr_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 4,
   parameter int DW   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*AW-1:0]  req_addr,
   input  logic [NREQ*DW-1:0]  req_data,
   output logic [NREQ-1:0]     req_ready,
   input  logic                wr_hold,
   output logic                write_en,
   output logic [AW-1:0]       write_address,
   output logic [DW-1:0]       write_data,
   output logic                pend_valid,
   output logic [AW-1:0]       pend_addr,
   output logic [2:0]          grant_id
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Handshake: a requester transfers on a rising edge where req_valid[i] and
   // req_ready[i] are both high; it holds addr/data stable until then.
   logic [PW-1:0]  rr_ptr;
   logic [PW-1:0]  winner;
   logic           found;
   logic           accept;
   logic [PW-1:0]  rr_ptr_nxt;
   logic [AW-1:0]  win_addr;
   logic [DW-1:0]  win_data;
   logic           commit_en;
   int             idx;

   // Search from rr_ptr upward, wrapping; only req_valid and rr_ptr steer the choice.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx[PW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (found && !wr_hold && !rst)
         req_ready[winner] = 1'b1;
   end

   assign accept     = |(req_valid & req_ready);
   assign rr_ptr_nxt = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
   assign win_addr   = req_addr[winner*AW +: AW];
   assign win_data   = req_data[winner*DW +: DW];

`ifdef REGFILE_WR_R0_ZERO_EN
   assign commit_en = accept && (win_addr != '0);
`else
   assign commit_en = accept;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr        <= '0;
         write_en      <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
         grant_id      <= '0;
      end else if (accept) begin
         rr_ptr        <= rr_ptr_nxt;
         write_en      <= commit_en;
         write_address <= win_addr;
         write_data    <= win_data;
         grant_id      <= 3'(winner);
      end else begin
         write_en      <= 1'b0;
      end
   end

   assign pend_valid = write_en;
   assign pend_addr  = write_address;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, single grant, fairness, hold, mid-stream reset, r0 write.
module tb_regfile_wr_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 4;
   localparam int DW   = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*AW-1:0]  req_addr;
   logic [NREQ*DW-1:0]  req_data;
   logic [NREQ-1:0]     req_ready;
   logic                wr_hold;
   logic                write_en;
   logic [AW-1:0]       write_address;
   logic [DW-1:0]       write_data;
   logic                pend_valid;
   logic [AW-1:0]       pend_addr;
   logic [2:0]          grant_id;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .wr_hold       (wr_hold),
      .write_en      (write_en),
      .write_address (write_address),
      .write_data    (write_data),
      .pend_valid    (pend_valid),
      .pend_addr     (pend_addr),
      .grant_id      (grant_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; registered outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic chk_wr(input string tag, input logic en, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [2:0] g);
      chk({tag, "_en"},   32'(write_en),      32'(en));
      chk({tag, "_pv"},   32'(pend_valid),    32'(en));
      chk({tag, "_addr"}, 32'(write_address), 32'(a));
      chk({tag, "_paddr"},32'(pend_addr),     32'(a));
      chk({tag, "_data"}, 32'(write_data),    32'(d));
      chk({tag, "_gid"},  32'(grant_id),      32'(g));
   endtask

   logic [2:0] fair_rdy [6];
   logic [2:0] fair_gid [6];

   initial begin
      rst       = 1'b1;
      wr_hold   = 1'b0;
      req_valid = 3'b111;
      req_addr  = '0;
      req_data  = '0;
      set_req(0, 4'd1, 16'h1111);
      set_req(1, 4'd2, 16'h2222);
      set_req(2, 4'd3, 16'h3333);
      #1;
      chk("rst_ready0", 32'(req_ready), 32'd0);

      // Reset held 2 cycles with every requester valid
      step();
      chk("rst_ready1", 32'(req_ready), 32'd0);
      chk_wr("rst1", 1'b0, 4'd0, 16'h0000, 3'd0);
      step();
      chk_wr("rst2", 1'b0, 4'd0, 16'h0000, 3'd0);
      rst = 1'b0;
      #1;
      chk("first_ready", 32'(req_ready), 32'b001);
      step();
      chk_wr("first", 1'b1, 4'd1, 16'h1111, 3'd0);
      req_valid = 3'b000;
      #1;
      chk("idle_ready", 32'(req_ready), 32'd0);
      step();
      chk("idle_en", 32'(write_en), 32'd0);
      chk("idle_hold_addr", 32'(write_address), 32'd1);

      // Single requester 1, rr_ptr now 1
      set_req(1, 4'd5, 16'hBEEF);
      req_valid = 3'b010;
      #1;
      chk("single_ready", 32'(req_ready), 32'b010);
      step();
      chk_wr("single", 1'b1, 4'd5, 16'hBEEF, 3'd1);
      req_valid = 3'b000;

      // Reset pulse to bring rr_ptr back to 0
      rst = 1'b1;
      step();
      rst = 1'b0;

      // Fairness: all valid for 6 cycles
      set_req(0, 4'd1, 16'hA000);
      set_req(1, 4'd2, 16'hA001);
      set_req(2, 4'd3, 16'hA002);
      fair_rdy = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      fair_gid = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
      req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk($sformatf("fair_ready%0d", c), 32'(req_ready), 32'(fair_rdy[c]));
         step();
         chk($sformatf("fair_en%0d", c), 32'(write_en), 32'd1);
         chk($sformatf("fair_gid%0d", c), 32'(grant_id), 32'(fair_gid[c]));
         chk($sformatf("fair_addr%0d", c), 32'(write_address), 32'(fair_gid[c]) + 32'd1);
      end

      // Hold: in-flight write to addr 3 from requester 0 (rr_ptr 0 -> 1)
      set_req(0, 4'd3, 16'h0303);
      req_valid = 3'b001;
      step();
      chk_wr("hold_inflight", 1'b1, 4'd3, 16'h0303, 3'd0);
      req_valid = 3'b111;
      wr_hold   = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("hold_ready%0d", c), 32'(req_ready), 32'd0);
         step();
         chk($sformatf("hold_en%0d", c), 32'(write_en), 32'd0);
         chk($sformatf("hold_gid%0d", c), 32'(grant_id), 32'd0);
         chk($sformatf("hold_addr%0d", c), 32'(write_address), 32'd3);
      end
      wr_hold = 1'b0;
      #1;
      chk("hold_resume_ready", 32'(req_ready), 32'b010);
      step();
      chk_wr("hold_resume", 1'b1, 4'd2, 16'hA001, 3'd1);

      // Reset while write_en=1; requests 0 and 2 presented during reset
      req_valid = 3'b101;
      rst = 1'b1;
      #1;
      chk("midrst_ready", 32'(req_ready), 32'd0);
      step();
      chk_wr("midrst", 1'b0, 4'd0, 16'h0000, 3'd0);
      rst = 1'b0;
      #1;
      chk("midrst_after_ready", 32'(req_ready), 32'b001);
      step();
      chk_wr("midrst_g0", 1'b1, 4'd3, 16'h0303, 3'd0);
      req_valid = 3'b100;
      #1;
      chk("midrst_r2_ready", 32'(req_ready), 32'b100);
      step();
      chk_wr("midrst_g2", 1'b1, 4'd3, 16'hA002, 3'd2);
      req_valid = 3'b000;
      step();
      chk("post_idle_en", 32'(write_en), 32'd0);

      // Requester 2 writes register 0 (rr_ptr is 0)
      set_req(2, 4'd0, 16'h1234);
      req_valid = 3'b100;
      #1;
      chk("r0_ready", 32'(req_ready), 32'b100);
      step();
`ifdef REGFILE_WR_R0_ZERO_EN
      chk("r0_en", 32'(write_en), 32'd0);
      chk("r0_pv", 32'(pend_valid), 32'd0);
      chk("r0_gid", 32'(grant_id), 32'd2);
`else
      chk_wr("r0", 1'b1, 4'd0, 16'h1234, 3'd2);
`endif
      req_valid = 3'b000;
      // rr_ptr advanced to 0 after granting 2; requester 0 wins against 1
      req_valid = 3'b011;
      #1;
      chk("r0_next_ready", 32'(req_ready), 32'b001);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
